// File: rtl/fwd_pkg.sv
// fwd_pkg
//   Shared types and constants for the forwarding / hazard controller.
//   - Forward-select encodings used on ex_fwd_sel.
//   - Scoreboard entry types. The EX entry carries the load flag because the
//     load-use decision is made against EX only. Once a load has left EX its
//     data is forwardable like any ALU result, so MEM and WB keep only the tag.
package fwd_pkg;

  // Widest register number the scoreboard can hold. Narrower REG_W values
  // are zero-extended into this field.
  localparam int MAX_REG_W = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;  // read the register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM pipeline register
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB pipeline register
  localparam logic [1:0] FWD_WB    = 2'b11;  // WB write-through

  // Full entry, used for the instruction entering or sitting in EX.
  typedef struct packed {
    logic                 v;
    logic                 wr;
    logic [MAX_REG_W-1:0] dst;
    logic                 ld;
  } sb_entry_t;

  // Tag-only entry, used for MEM and WB.
  typedef struct packed {
    logic                 v;
    logic                 wr;
    logic [MAX_REG_W-1:0] dst;
  } sb_tag_t;

  localparam int SB_W  = $bits(sb_entry_t);
  localparam int TAG_W = $bits(sb_tag_t);

  function automatic sb_tag_t tag_of(input sb_entry_t e);
    sb_tag_t t;
    t.v   = e.v;
    t.wr  = e.wr;
    t.dst = e.dst;
    return t;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match
//   Compares one ID source operand against the EX, MEM and WB scoreboard
//   entries and produces the forward select for that operand plus a
//   load-use hit flag.
// Ports:
//   i_id_valid   ID stage holds a valid instruction
//   i_src_valid  this operand is actually read
//   i_src_reg    source register number
//   i_ex         EX entry (packed sb_entry_t)
//   i_mem        MEM tag (packed sb_tag_t)
//   i_wb         WB tag (packed sb_tag_t)
//   o_sel        forward select, newest producer first
//   o_lu_hit     operand depends on a load currently in EX
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_W     = 3,
  parameter int ZERO_HARD = 0
) (
  input  logic             i_id_valid,
  input  logic             i_src_valid,
  input  logic [REG_W-1:0] i_src_reg,
  input  logic [SB_W-1:0]  i_ex,
  input  logic [TAG_W-1:0] i_mem,
  input  logic [TAG_W-1:0] i_wb,
  output logic [1:0]       o_sel,
  output logic             o_lu_hit
);

  sb_entry_t            w_ex;
  sb_tag_t              w_mem;
  sb_tag_t              w_wb;
  logic [MAX_REG_W-1:0] w_src_ext;
  logic                 w_src_ok;
  logic                 w_hit_ex;
  logic                 w_hit_mem;
  logic                 w_hit_wb;

  assign w_ex  = sb_entry_t'(i_ex);
  assign w_mem = sb_tag_t'(i_mem);
  assign w_wb  = sb_tag_t'(i_wb);

  // Qualify the operand once; a hard-wired r0 never creates a dependency.
  always_comb begin
    w_src_ext                = '0;
    w_src_ext[REG_W-1:0]     = i_src_reg;
    w_src_ok                 = i_id_valid & i_src_valid;
    if ((ZERO_HARD != 0) && (i_src_reg == '0)) begin
      w_src_ok = 1'b0;
    end
  end

  assign w_hit_ex  = w_src_ok & w_ex.v  & w_ex.wr  & (w_ex.dst  == w_src_ext);
  assign w_hit_mem = w_src_ok & w_mem.v & w_mem.wr & (w_mem.dst == w_src_ext);
  assign w_hit_wb  = w_src_ok & w_wb.v  & w_wb.wr  & (w_wb.dst  == w_src_ext);

  assign o_lu_hit = w_hit_ex & w_ex.ld;

  // Youngest producer wins. A load in EX has no data yet, so it is skipped
  // here; the resulting stall makes this select irrelevant for that cycle.
  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_ex && !w_ex.ld) begin
      o_sel = FWD_EXMEM;
    end else if (w_hit_mem) begin
      o_sel = FWD_MEMWB;
    end else if (w_hit_wb) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctl.sv
// fwd_hazard_ctl
//   Forwarding and hazard controller for a 5-stage pipe. Keeps a three-deep
//   in-flight write scoreboard (EX, MEM, WB), computes forward selects in ID
//   and registers them into EX, and generates load-use / memory-busy stalls,
//   bubble insertion and flush handling.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   id_valid        valid instruction in ID
//   id_src_valid    per-source "operand is read" flags
//   id_src_reg      packed source register numbers, src i at [i*REG_W +: REG_W]
//   id_wr_en        ID instruction writes the register file
//   id_dst_reg      ID destination register
//   id_is_load      ID instruction is a load
//   mem_busy        data memory not ready, whole pipe freezes
//   flush           kill the ID instruction
//   stall           hold PC and IF/ID (combinational)
//   ex_bubble       EX holds a bubble this cycle (registered)
//   ex_fwd_sel      per-source forward select for the EX instruction (registered)
// Handshake: there is no valid/ready pair here; stall is the single
//   back-pressure signal and is valid in the same cycle as the ID inputs.
module fwd_hazard_ctl
  import fwd_pkg::*;
#(
  parameter int REG_W     = 3,
  parameter int NUM_SRC   = 2,
  parameter int ZERO_HARD = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC-1:0]       id_src_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src_reg,
  input  logic                     id_wr_en,
  input  logic [REG_W-1:0]         id_dst_reg,
  input  logic                     id_is_load,
  input  logic                     mem_busy,
  input  logic                     flush,
  output logic                     stall,
  output logic                     ex_bubble,
  output logic [NUM_SRC*2-1:0]     ex_fwd_sel
);

  sb_entry_t              r_ex;
  sb_tag_t                r_mem;
  sb_tag_t                r_wb;
  logic                   r_bubble;
  logic [NUM_SRC*2-1:0]   r_sel;

  sb_entry_t              w_id_ent;
  logic [NUM_SRC-1:0]     w_lu_hit;
  logic [NUM_SRC*2-1:0]   w_sel;
  logic                   w_lu;
  logic                   w_issue;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(
      .REG_W     (REG_W),
      .ZERO_HARD (ZERO_HARD)
    ) u_match (
      .i_id_valid  (id_valid),
      .i_src_valid (id_src_valid[g]),
      .i_src_reg   (id_src_reg[g*REG_W +: REG_W]),
      .i_ex        (r_ex),
      .i_mem       (r_mem),
      .i_wb        (r_wb),
      .o_sel       (w_sel[2*g +: 2]),
      .o_lu_hit    (w_lu_hit[g])
    );
  end

  always_comb begin
    w_id_ent                = '0;
    w_id_ent.v              = 1'b1;
    w_id_ent.wr             = id_wr_en;
    w_id_ent.dst[REG_W-1:0] = id_dst_reg;
    w_id_ent.ld             = id_is_load;
  end

  // Priority: mem_busy freezes everything, flush overrides a load-use stall.
  assign w_lu    = |w_lu_hit;
  assign w_issue = id_valid & ~flush & ~w_lu;
  assign stall   = mem_busy | (w_lu & ~flush);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_bubble <= 1'b1;
      r_sel    <= '0;
    end else if (!mem_busy) begin
      r_wb     <= r_mem;
      r_mem    <= tag_of(r_ex);
      r_ex     <= w_issue ? w_id_ent : '0;
      r_bubble <= ~w_issue;
      r_sel    <= w_issue ? w_sel : '0;
    end
  end

  assign ex_bubble  = r_bubble;
  assign ex_fwd_sel = r_sel;

endmodule

// File: tb/tb_fwd_hazard_ctl.sv
// tb_fwd_hazard_ctl
//   Directed bench for fwd_hazard_ctl with NUM_SRC=3, ZERO_HARD=1.
//   Each vector is one ID cycle: inputs, expected stall in that cycle, and
//   expected ex_bubble / ex_fwd_sel after the following clock edge.
module tb_fwd_hazard_ctl;

  localparam int REG_W   = 3;
  localparam int NUM_SRC = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     id_valid;
  logic [NUM_SRC-1:0]       id_src_valid;
  logic [NUM_SRC*REG_W-1:0] id_src_reg;
  logic                     id_wr_en;
  logic [REG_W-1:0]         id_dst_reg;
  logic                     id_is_load;
  logic                     mem_busy;
  logic                     flush;
  logic                     stall;
  logic                     ex_bubble;
  logic [NUM_SRC*2-1:0]     ex_fwd_sel;

  fwd_hazard_ctl #(
    .REG_W     (REG_W),
    .NUM_SRC   (NUM_SRC),
    .ZERO_HARD (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src_valid (id_src_valid),
    .id_src_reg   (id_src_reg),
    .id_wr_en     (id_wr_en),
    .id_dst_reg   (id_dst_reg),
    .id_is_load   (id_is_load),
    .mem_busy     (mem_busy),
    .flush        (flush),
    .stall        (stall),
    .ex_bubble    (ex_bubble),
    .ex_fwd_sel   (ex_fwd_sel)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic       v;
    logic [2:0] sv;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       wr;
    logic [2:0] dst;
    logic       ld;
    logic       mb;
    logic       fl;
    logic       e_stall;
    logic       e_bub;
    logic [5:0] e_sel;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [2:0] sv,
                              input logic [2:0] s0, input logic [2:0] s1,
                              input logic [2:0] s2, input logic wr,
                              input logic [2:0] dst, input logic ld,
                              input logic mb, input logic fl,
                              input logic e_stall, input logic e_bub,
                              input logic [5:0] e_sel);
    vec_t r;
    r.v = v; r.sv = sv; r.s0 = s0; r.s1 = s1; r.s2 = s2;
    r.wr = wr; r.dst = dst; r.ld = ld; r.mb = mb; r.fl = fl;
    r.e_stall = e_stall; r.e_bub = e_bub; r.e_sel = e_sel;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input vec_t t);
    id_valid     = t.v;
    id_src_valid = t.sv;
    id_src_reg   = {t.s2, t.s1, t.s0};
    id_wr_en     = t.wr;
    id_dst_reg   = t.dst;
    id_is_load   = t.ld;
    mem_busy     = t.mb;
    flush        = t.fl;
  endtask

  // Called just after a rising edge; consumes one clock cycle.
  task automatic apply(input string name, input vec_t t);
    logic [6:0] e;
    drive(t);
    exp_q.push_back({t.e_bub, t.e_sel});
    @(negedge clk);
    check({name, " stall"}, {7'd0, stall}, {7'd0, t.e_stall});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({name, " bubble"}, {7'd0, ex_bubble}, {7'd0, e[6]});
    check({name, " sel"}, {2'd0, ex_fwd_sel}, {2'd0, e[5:0]});
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000);
    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall",  {7'd0, stall},      8'd0);
    check("reset bubble", {7'd0, ex_bubble},  8'd1);
    check("reset sel",    {2'd0, ex_fwd_sel}, 8'd0);
    rst_n = 1'b1;

    //              v  sv      s0 s1 s2 wr dst ld mb fl  stall bub sel
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 6'b000000)); // ADD wr r3
    tbl.push_back(mk(1, 3'b001, 3, 0, 0, 1, 6, 0, 0, 0, 0, 0, 6'b000001)); // back-to-back
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 6'b000000)); // wr r5
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000)); // unrelated
    tbl.push_back(mk(1, 3'b111, 5, 6, 3, 0, 0, 0, 0, 0, 0, 0, 6'b001110)); // dist 2/3/4
    tbl.push_back(mk(1, 3'b001, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000011)); // dist 3
    tbl.push_back(mk(1, 3'b001, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000)); // dist 4
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 6'b000000)); // LD r2
    tbl.push_back(mk(1, 3'b001, 2, 0, 0, 1, 7, 0, 0, 0, 1, 1, 6'b000000)); // load-use
    tbl.push_back(mk(1, 3'b001, 2, 0, 0, 1, 7, 0, 0, 0, 0, 0, 6'b000010)); // retry
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 6'b000000)); // LD r4
    tbl.push_back(mk(1, 3'b001, 4, 0, 0, 1, 7, 0, 0, 1, 0, 1, 6'b000000)); // flush wins
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6'b000000)); // wr r1 (old)
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6'b000000)); // wr r1 (new)
    tbl.push_back(mk(1, 3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001)); // youngest wins
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 6'b000000)); // wr r6
    tbl.push_back(mk(1, 3'b010, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001100)); // src0 invalid
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 6'b000000)); // LD r3
    tbl.push_back(mk(1, 3'b010, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001100)); // invalid src no lu
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b000000)); // wr r0
    tbl.push_back(mk(1, 3'b101, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 6'b110000)); // r0 never fwd
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 6'b000000)); // LD r0
    tbl.push_back(mk(1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000)); // r0 never stalls
    tbl.push_back(mk(1, 3'b000, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 6'b000000)); // LD r5
    tbl.push_back(mk(0, 3'b001, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000)); // id_valid=0

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("row%0d", i), tbl[i]);
    end

    // mem_busy held three cycles with a nonzero select in EX.
    apply("mb0", mk(1, 3'b000, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 6'b000000));
    apply("mb1", mk(1, 3'b001, 6, 0, 0, 1, 5, 0, 0, 0, 0, 0, 6'b000001));
    for (int k = 0; k < 3; k++) begin
      apply($sformatf("mb_hold%0d", k),
            mk(1, 3'b011, 5, 6, 0, 0, 0, 0, 1, 0, 1, 0, 6'b000001));
    end
    apply("mb_release", mk(1, 3'b011, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001));

    // Reset asserted while a load-use stall is active.
    apply("rst_ld", mk(1, 3'b000, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 6'b000000));
    drive(mk(1, 3'b001, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    @(negedge clk);
    check("rst_lu stall_before", {7'd0, stall}, 8'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_lu stall_after",  {7'd0, stall},      8'd0);
    check("rst_lu bubble",       {7'd0, ex_bubble},  8'd1);
    check("rst_lu sel",          {2'd0, ex_fwd_sel}, 8'd0);
    rst_n = 1'b1;
    apply("rst_retry", mk(1, 3'b001, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
